// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared widths and types for the SRAM arbiter
package sram_arb_pkg;
  localparam int SRAM_ADDR_W = 9;
  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_RD_LAT = 1;
  typedef logic [1:0] req_id_t;
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_pipe_t;
endpackage

// File: rtl/sram_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first valid at ptr+1 upward modulo N
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);
  logic [PW-1:0] c;
  always_comb begin
    any = 1'b0;
    idx = '0;
    c   = '0;
    for (int k = N; k >= 1; k--) begin
      c = PW'((int'(ptr) + k) % N);
      if (valid[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/sram_arb.sv
// sram_arb: round-robin arbiter sharing one single-port SRAM macro between requesters.
// SRAM_ARB_PRIO_EN gives requester 0 absolute priority over the round-robin group.
module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int DATA_W  = SRAM_DATA_W,
  parameter int RD_LAT  = SRAM_RD_LAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*DATA_W-1:0] req_wmask,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      csb0,
  output logic                      web0,
  output logic [DATA_W-1:0]         wmask0,
  output logic [ADDR_W-1:0]         addr0,
  output logic [DATA_W-1:0]         din0,
  input  logic [DATA_W-1:0]         dout0
);
  localparam int PW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] pick_valid, pick_grant, grant;
  logic [PW-1:0]      pick_idx, win, ptr;
  logic               pick_any, any, gnt, ptr_upd;
  rd_pipe_t           pipe [RD_LAT];
  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .valid(pick_valid),
    .ptr  (ptr),
    .grant(pick_grant),
    .idx  (pick_idx),
    .any  (pick_any)
  );
`ifdef SRAM_ARB_PRIO_EN
  assign pick_valid = req_valid & ~NUM_REQ'(1);
  assign any        = req_valid[0] | pick_any;
  assign win        = req_valid[0] ? '0 : pick_idx;
  assign grant      = req_valid[0] ? NUM_REQ'(1) : pick_grant;
  assign ptr_upd    = ~req_valid[0];
`else
  assign pick_valid = req_valid;
  assign any        = pick_any;
  assign win        = pick_idx;
  assign grant      = pick_grant;
  assign ptr_upd    = 1'b1;
`endif
  assign gnt       = any & ~rst;
  assign req_ready = gnt ? grant : '0;
  assign csb0      = ~gnt;
  assign web0      = gnt ? ~req_we[win] : 1'b1;
  assign addr0     = gnt ? req_addr[win*ADDR_W +: ADDR_W] : '0;
  assign din0      = gnt ? req_wdata[win*DATA_W +: DATA_W] : '0;
  assign wmask0    = gnt ? req_wmask[win*DATA_W +: DATA_W] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PW'(NUM_REQ - 1);
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      if (gnt && ptr_upd) ptr <= win;
      pipe[0] <= '{valid: gnt & ~req_we[win], id: req_id_t'(win)};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  // Reads still in flight when reset asserts must never strobe.
  assign rsp_valid = (pipe[RD_LAT-1].valid && !rst) ? NUM_REQ'(1) << pipe[RD_LAT-1].id : '0;
  assign rsp_data  = dout0;
endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: randomized and directed checks of sram_arb against a queue-free behavioural model
module tb_sram_arb;
  localparam int N  = 2;
  localparam int AW = 9;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, req_wmask;
  logic [DW-1:0]   rsp_data, wmask0, din0, dout0;
  logic [AW-1:0]   addr0;
  logic            csb0, web0;
  bit   [31:0]     mem [512];
  bit   [31:0]     ref_mem [512];
  logic            pl_en = 1'b0;
  logic [8:0]      pl_addr;
  logic [31:0]     pl_data;
  int              n_tests = 0, n_fail = 0, m_ptr;
  logic            exp_v;
  int              exp_id;
  logic [31:0]     exp_d;

  sram_arb #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] = pl_data;
    if (!csb0) begin
      if (!web0) mem[addr0] = (mem[addr0] & ~wmask0) | (din0 & wmask0);
      else dout0 <= mem[addr0];
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  function automatic int model_pick(logic [N-1:0] v_in, int p);
    logic [N-1:0] v;
    v = v_in;
`ifdef SRAM_ARB_PRIO_EN
    if (v[0]) return 0;
    v[0] = 1'b0;
`endif
    for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_req(int i, logic v, logic we, logic [8:0] a, logic [31:0] d, logic [31:0] m);
    req_valid[i] = v;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_wmask[i*DW +: DW] = m;
  endtask

  task automatic tick();
    int w, nid;
    logic nv;
    logic [31:0] nd;
    logic [8:0] a;
    w = rst ? -1 : model_pick(req_valid, m_ptr);
    nv = 1'b0; nid = 0; nd = '0;
    if (rst) m_ptr = N - 1;
    else if (w >= 0) begin
`ifdef SRAM_ARB_PRIO_EN
      if (w != 0) m_ptr = w;
`else
      m_ptr = w;
`endif
      a = req_addr[w*AW +: AW];
      if (req_we[w])
        ref_mem[a] = (ref_mem[a] & ~req_wmask[w*DW +: DW]) | (req_wdata[w*DW +: DW] & req_wmask[w*DW +: DW]);
      else begin
        nv = 1'b1; nid = w; nd = ref_mem[a];
      end
    end
    @(posedge clk); #1;
    exp_v = nv; exp_id = nid; exp_d = nd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 9'h0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      pl_en = (c < 2);
      pl_addr = (c == 0) ? 9'h1A5 : 9'h010;
      pl_data = (c == 0) ? 32'hDEADBEEF : 32'hAAAAAAAA;
      if (c < 2) ref_mem[pl_addr] = pl_data;
      @(negedge clk);
      n_tests++;
      if ({req_ready, csb0, rsp_valid} !== {2'b00, 1'b1, 2'b00}) begin
        n_fail++;
        $display("FAIL reset_idle: got ready=%b csb0=%b rsp_valid=%b expected 00 1 00", req_ready, csb0, rsp_valid);
      end
      tick();
    end
    pl_en = 1'b0;
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single_read();
    set_req(1, 1'b1, 1'b0, 9'h1A5, '0, '0);
    @(negedge clk);
    n_tests++;
    if ({req_ready, csb0, web0, addr0} !== {2'b10, 1'b0, 1'b1, 9'h1A5}) begin
      n_fail++;
      $display("FAIL single_read_grant: got ready=%b csb0=%b web0=%b addr0=%h expected 10 0 1 1a5", req_ready, csb0, web0, addr0);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_tests++;
    if ({rsp_valid, rsp_data} !== {2'b10, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL single_read_rsp: got %b %h expected 10 deadbeef", rsp_valid, rsp_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n_rsp = 0;
    set_req(0, 1'b1, 1'b0, 9'h010, '0, '0);
    set_req(1, 1'b1, 1'b0, 9'h1A5, '0, '0);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) req_valid = '0;
      @(negedge clk);
      if (rsp_valid != '0) n_rsp++;
      if (i < 6) begin
        n_tests++;
        if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
          n_fail++;
          $display("FAIL b2b_grant%0d: got %b expected %b", i, req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
      end
      if (i > 0) begin
        n_tests++;
        if ({rsp_valid, rsp_data} !== {((i % 2 == 1) ? 2'b01 : 2'b10), exp_d}) begin
          n_fail++;
          $display("FAIL b2b_rsp%0d: got %b %h expected %b %h", i, rsp_valid, rsp_data, (i % 2 == 1) ? 2'b01 : 2'b10, exp_d);
        end
      end
      tick();
    end
    n_tests++;
    if (n_rsp != 6) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d responses expected 6", n_rsp);
    end
  endtask

  task automatic test_write_read();
    set_req(0, 1'b1, 1'b1, 9'h010, 32'h12345678, 32'h0000FFFF);
    @(negedge clk);
    n_tests++;
    if ({req_ready, csb0, web0, addr0, din0, wmask0} !== {2'b01, 1'b0, 1'b0, 9'h010, 32'h12345678, 32'h0000FFFF}) begin
      n_fail++;
      $display("FAIL write_drive: got ready=%b csb0=%b web0=%b addr0=%h din0=%h wmask0=%h", req_ready, csb0, web0, addr0, din0, wmask0);
    end
    tick();
    set_req(0, 1'b1, 1'b0, 9'h010, '0, '0);
    @(negedge clk);
    n_tests++;
    if ({rsp_valid, req_ready} !== {2'b00, 2'b01}) begin
      n_fail++;
      $display("FAIL write_no_rsp: got rsp_valid=%b ready=%b expected 00 01", rsp_valid, req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_tests++;
    if ({rsp_valid, rsp_data} !== {2'b01, 32'hAAAA5678}) begin
      n_fail++;
      $display("FAIL write_readback: got %b %h expected 01 aaaa5678", rsp_valid, rsp_data);
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    set_req(0, 1'b1, 1'b0, 9'h010, '0, '0);
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL inflight_grant: got %b expected 01", req_ready);
    end
    tick();
    rst = 1'b1;
    set_req(1, 1'b1, 1'b0, 9'h1A5, '0, '0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++;
      if ({rsp_valid, req_ready, csb0} !== {2'b00, 2'b00, 1'b1}) begin
        n_fail++;
        $display("FAIL inflight_drop%0d: got rsp_valid=%b ready=%b csb0=%b expected 00 00 1", c, rsp_valid, req_ready, csb0);
      end
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({req_ready, csb0} !== {2'b01, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_grant: got ready=%b csb0=%b expected 01 0", req_ready, csb0);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_tests++;
    if ({rsp_valid, rsp_data} !== {2'b01, exp_d}) begin
      n_fail++;
      $display("FAIL post_reset_rsp: got %b %h expected 01 %h", rsp_valid, rsp_data, exp_d);
    end
    tick();
  endtask

  task automatic test_prio();
`ifdef SRAM_ARB_PRIO_EN
    set_req(0, 1'b1, 1'b0, 9'h010, '0, '0);
    set_req(1, 1'b1, 1'b0, 9'h1A5, '0, '0);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) req_valid[0] = 1'b0;
      @(negedge clk);
      n_tests++;
      if (req_ready !== ((c < 4) ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL prio_grant%0d: got %b expected %b", c, req_ready, (c < 4) ? 2'b01 : 2'b10);
      end
      tick();
    end
    req_valid = '0;
    tick();
`endif
  endtask

  task automatic test_idle();
    int w;
    req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tests++;
      if ({req_ready, csb0, web0, addr0, din0, wmask0, rsp_valid} !==
          {2'b00, 1'b1, 1'b1, 9'h0, 32'h0, 32'h0, (exp_v ? N'(1) << exp_id : N'(0))}) begin
        n_fail++;
        $display("FAIL idle%0d: got ready=%b csb0=%b web0=%b addr0=%h din0=%h wmask0=%h rsp_valid=%b", c, req_ready, csb0, web0, addr0, din0, wmask0, rsp_valid);
      end
      tick();
    end
    set_req(0, 1'b1, 1'b0, 9'h003, '0, '0);
    set_req(1, 1'b1, 1'b0, 9'h004, '0, '0);
    @(negedge clk);
    w = model_pick(req_valid, m_ptr);
    n_tests++;
    if (req_ready !== N'(1) << w) begin
      n_fail++;
      $display("FAIL idle_ptr_hold: got %b expected %b", req_ready, N'(1) << w);
    end
    tick();
    req_valid = 2'b10;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL idle_then_req1: got %b expected 10", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    int w, last_w;
    logic [74:0] em;
    last_w = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || last_w == i)
          set_req(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), $urandom, $urandom);
      @(negedge clk);
      w = model_pick(req_valid, m_ptr);
      em = (w >= 0) ? {1'b0, ~req_we[w], req_addr[w*AW +: AW], req_wdata[w*DW +: DW], req_wmask[w*DW +: DW]}
                    : {2'b11, 73'h0};
      n_tests++;
      if ({req_ready, csb0, web0, addr0, din0, wmask0} !== {((w >= 0) ? N'(1) << w : N'(0)), em}) begin
        n_fail++;
        $display("FAIL rand_drive%0d: got ready=%b csb0=%b web0=%b addr0=%h expected winner %0d", c, req_ready, csb0, web0, addr0, w);
      end
      n_tests++;
      if (rsp_valid !== (exp_v ? N'(1) << exp_id : N'(0)) || (exp_v && rsp_data !== exp_d)) begin
        n_fail++;
        $display("FAIL rand_rsp%0d: got %b %h expected %b %h", c, rsp_valid, rsp_data, exp_v ? N'(1) << exp_id : N'(0), exp_d);
      end
      last_w = w;
      tick();
    end
    req_valid = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    m_ptr = N - 1;
    exp_v = 1'b0; exp_id = 0; exp_d = '0;
    @(posedge clk); #1;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write_read();
    test_reset_inflight();
    test_prio();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
